bp_mem_port_mux: RTL and testbench

BP_MEM_PORT_MUX -- requirements
Module: bp_mem_port_mux

---
 rtl/bp_mem_port_mux.sv | 134 +++++++++++++
 tb/tb_bp_mem_port_mux.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_port_mux.sv
// Round-robin mux of several requester ports onto one in-order memory port, with responses routed back by an order FIFO.
// Optional checks are compiled in with `define BP_MEM_PORT_MUX_ASSERT_EN.
package bp_mem_port_mux_pkg;
  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_narrow_cfg  = 2'd1
  } bp_params_e;

  function automatic int mem_msg_width(bp_params_e cfg);
    return (cfg == e_bp_narrow_cfg) ? 32 : 64;
  endfunction
endpackage

module bp_mem_port_mux
  import bp_mem_port_mux_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_ports_p = 2,
  parameter int order_els_p = 4,
  localparam int msg_w_lp = mem_msg_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [num_ports_p*msg_w_lp-1:0] port_cmd_i,
  input  logic [num_ports_p-1:0]          port_cmd_v_i,
  output logic [num_ports_p-1:0]          port_cmd_ready_o,
  output logic [msg_w_lp-1:0]             port_resp_o,
  output logic [num_ports_p-1:0]          port_resp_v_o,
  input  logic [num_ports_p-1:0]          port_resp_yumi_i,
  output logic [msg_w_lp-1:0]             mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [msg_w_lp-1:0]             mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o
);
  localparam int port_w_lp = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
  localparam int ptr_w_lp  = $clog2(order_els_p);
  localparam int cnt_w_lp  = $clog2(order_els_p + 1);

  logic [port_w_lp-1:0] order_q [order_els_p];
  logic [ptr_w_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [port_w_lp-1:0] last_grant_q, last_grant_d;
  logic [port_w_lp-1:0] grant, head;
  logic                 found, full, empty, push, pop, resp_v;
  int                   rr_idx;

  // Full is taken from the registered count so a same-cycle pop never frees a slot early.
  assign full  = (cnt_q == cnt_w_lp'(order_els_p));
  assign empty = (cnt_q == '0);
  assign head  = order_q[rptr_q];
  assign port_resp_o = mem_resp_i;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 1; k <= num_ports_p; k++) begin
      rr_idx = int'(last_grant_q) + k;
      if (rr_idx >= num_ports_p) rr_idx = rr_idx - num_ports_p;
      if (!found && port_cmd_v_i[rr_idx]) begin
        found = 1'b1;
        grant = port_w_lp'(rr_idx);
      end
    end
  end

  always_comb begin
    mem_cmd_v_o             = ~reset_i & (|port_cmd_v_i) & ~full;
    mem_cmd_o               = port_cmd_i[grant*msg_w_lp +: msg_w_lp];
    push                    = mem_cmd_v_o & mem_cmd_ready_i;
    port_cmd_ready_o        = '0;
    port_cmd_ready_o[grant] = push;
    resp_v                  = ~reset_i & mem_resp_v_i & ~empty;
    port_resp_v_o           = '0;
    port_resp_v_o[head]     = resp_v;
    mem_resp_yumi_o         = resp_v & port_resp_yumi_i[head];
    pop                     = mem_resp_yumi_o;
  end

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    if (push) begin
      wptr_d       = (wptr_q == ptr_w_lp'(order_els_p - 1)) ? '0 : wptr_q + 1'b1;
      last_grant_d = grant;
    end
    if (pop) begin
      rptr_d = (rptr_q == ptr_w_lp'(order_els_p - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= port_w_lp'(num_ports_p - 1);
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) order_q[wptr_q] <= grant;
  end

`ifdef BP_MEM_PORT_MUX_ASSERT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (mem_resp_v_i && empty)
        $error("bp_mem_port_mux: memory response with no outstanding command");
      if (!empty && (|(port_resp_yumi_i & ~(num_ports_p'(1) << head))))
        $error("bp_mem_port_mux: yumi on a port that is not the order head");
      if (push && !pop && full)
        $error("bp_mem_port_mux: outstanding counter overflow");
      if (pop && !push && empty)
        $error("bp_mem_port_mux: outstanding counter underflow");
    end
  end
`endif

endmodule

// File: tb/tb_bp_mem_port_mux.sv
// Randomized and directed bench for bp_mem_port_mux (3 ports, 4 outstanding) against a queue-based reference model.
module tb_bp_mem_port_mux;
  import bp_mem_port_mux_pkg::*;
  localparam int NP  = 3;
  localparam int ORD = 4;
  localparam int W   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [NP*W-1:0] cmd = '0;
  logic [NP-1:0]   cmd_v = '0, yumi = '0;
  logic [NP-1:0]   cmd_rdy, resp_v;
  logic [W-1:0]    resp, mcmd;
  logic [W-1:0]    mresp = '0;
  logic            mcmd_v, myumi;
  logic            mrdy = 1'b0, mresp_v = 1'b0;

  bp_mem_port_mux #(.bp_params_p(e_bp_default_cfg), .num_ports_p(NP), .order_els_p(ORD)) dut (
    .clk_i(clk), .reset_i(rst),
    .port_cmd_i(cmd), .port_cmd_v_i(cmd_v), .port_cmd_ready_o(cmd_rdy),
    .port_resp_o(resp), .port_resp_v_o(resp_v), .port_resp_yumi_i(yumi),
    .mem_cmd_o(mcmd), .mem_cmd_v_o(mcmd_v), .mem_cmd_ready_i(mrdy),
    .mem_resp_i(mresp), .mem_resp_v_i(mresp_v), .mem_resp_yumi_o(myumi)
  );

  int n_chk = 0, n_fail = 0;
  int q[$];
  int last = NP - 1;
  logic          exp_cv, exp_y;
  int            exp_g;
  logic [NP-1:0] exp_rdy, exp_rv;
  logic [W-1:0]  exp_cmd;

  // Reference: grant = first valid port after the last grant; order = queue of granted ports.
  function automatic void predict();
    bit hit;
    exp_cv = 0; exp_g = 0; exp_rdy = '0; exp_rv = '0; exp_y = 0; exp_cmd = '0;
    if (rst) return;
    exp_cv = (cmd_v != '0) && (q.size() < ORD);
    hit = 0;
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (!hit && cmd_v[p]) begin hit = 1; exp_g = p; end
    end
    exp_cmd = cmd[exp_g*W +: W];
    if (exp_cv && mrdy) exp_rdy[exp_g] = 1'b1;
    if (mresp_v && q.size() > 0) begin
      exp_rv[q[0]] = 1'b1;
      exp_y = yumi[q[0]];
    end
  endfunction

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst) begin
      q.delete();
      last = NP - 1;
    end else begin
      if (exp_y) void'(q.pop_front());
      if (exp_cv && mrdy) begin q.push_back(exp_g); last = exp_g; end
    end
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < NP; i++) cmd[i*W +: W] = {32'hC0DE0000 | i, $urandom};
    mresp = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1; cmd_v = '0; mrdy = 0; mresp_v = 0; yumi = '0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; cmd_v = '1; mrdy = 1; mresp_v = 1; yumi = '1; set_data();
    #2;
    n_chk++; if (cmd_rdy !== '0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 000", cmd_rdy); end
    n_chk++; if (resp_v !== '0) begin n_fail++; $display("FAIL reset_resp_v: got %b expected 000", resp_v); end
    n_chk++; if (mcmd_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_cmd_v: got %b expected 0", mcmd_v); end
    n_chk++; if (myumi !== 1'b0) begin n_fail++; $display("FAIL reset_mem_yumi: got %b expected 0", myumi); end
    tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] e;
    do_reset();
    cmd_v = 3'b011; mrdy = 1; mresp_v = 1; yumi = '1;
    for (int i = 0; i < 8; i++) begin
      set_data();
      #2; predict();
      e = '0; e[i%2] = 1'b1;
      n_chk++; if (cmd_rdy !== e) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, cmd_rdy, e); end
      n_chk++; if (mcmd !== cmd[(i%2)*W +: W]) begin n_fail++; $display("FAIL rr_cmd_data[%0d]: got %h expected %h", i, mcmd, cmd[(i%2)*W +: W]); end
      n_chk++; if (resp_v !== exp_rv) begin n_fail++; $display("FAIL rr_resp_v[%0d]: got %b expected %b", i, resp_v, exp_rv); end
      tick();
    end
  endtask

  task automatic test_outstanding_limit();
    int acc;
    acc = 0;
    do_reset();
    cmd_v = 3'b001; mrdy = 1; mresp_v = 0; yumi = '0;
    for (int i = 0; i < 6; i++) begin
      set_data();
      #2; predict();
      n_chk++; if (mcmd_v !== exp_cv) begin n_fail++; $display("FAIL limit_cmd_v[%0d]: got %b expected %b", i, mcmd_v, exp_cv); end
      if (cmd_rdy[0] === 1'b1) acc++;
      tick();
    end
    n_chk++; if (acc != ORD) begin n_fail++; $display("FAIL limit_accepted: got %0d expected %0d", acc, ORD); end
    #2;
    n_chk++; if (mcmd_v !== 1'b0) begin n_fail++; $display("FAIL limit_blocked: got %b expected 0", mcmd_v); end
    tick();
  endtask

  task automatic test_order();
    int            ports[3];
    logic [W-1:0]  vals[3];
    logic [NP-1:0] e;
    ports = '{2, 0, 1};
    vals  = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C};
    do_reset();
    mrdy = 1; mresp_v = 0; yumi = '0;
    for (int j = 0; j < 3; j++) begin
      cmd_v = '0; cmd_v[ports[j]] = 1'b1; set_data();
      #2;
      n_chk++; if (cmd_rdy !== cmd_v) begin n_fail++; $display("FAIL order_grant[%0d]: got %b expected %b", j, cmd_rdy, cmd_v); end
      tick();
    end
    cmd_v = '0; mresp_v = 1; mresp = vals[0]; yumi = 3'b011;
    #2;
    n_chk++; if (myumi !== 1'b0) begin n_fail++; $display("FAIL nonhead_yumi: got %b expected 0", myumi); end
    n_chk++; if (resp_v !== 3'b100) begin n_fail++; $display("FAIL nonhead_resp_v: got %b expected 100", resp_v); end
    tick();
    for (int j = 0; j < 3; j++) begin
      mresp = vals[j]; yumi = '1;
      e = '0; e[ports[j]] = 1'b1;
      #2;
      n_chk++; if (resp_v !== e) begin n_fail++; $display("FAIL order_resp_v[%0d]: got %b expected %b", j, resp_v, e); end
      n_chk++; if (resp !== vals[j]) begin n_fail++; $display("FAIL order_resp_data[%0d]: got %h expected %h", j, resp, vals[j]); end
      n_chk++; if (myumi !== 1'b1) begin n_fail++; $display("FAIL order_yumi[%0d]: got %b expected 1", j, myumi); end
      tick();
    end
    mresp_v = 0; yumi = '0;
  endtask

  task automatic test_full_pop();
    do_reset();
    cmd_v = 3'b001; mrdy = 1; mresp_v = 0; yumi = '0;
    repeat (ORD) tick();
    cmd_v = 3'b010; mresp_v = 1; yumi = '1;
    #2;
    n_chk++; if (mcmd_v !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_push: got %b expected 0", mcmd_v); end
    n_chk++; if (cmd_rdy !== 3'b000) begin n_fail++; $display("FAIL full_pop_ready: got %b expected 000", cmd_rdy); end
    n_chk++; if (myumi !== 1'b1) begin n_fail++; $display("FAIL full_pop_yumi: got %b expected 1", myumi); end
    tick();
    mresp_v = 0; yumi = '0;
    #2;
    n_chk++; if (cmd_rdy !== 3'b010) begin n_fail++; $display("FAIL full_next_push: got %b expected 010", cmd_rdy); end
    tick();
    #2;
    n_chk++; if (mcmd_v !== 1'b0) begin n_fail++; $display("FAIL full_count_held: got %b expected 0", mcmd_v); end
    tick();
  endtask

  task automatic test_empty_resp();
    do_reset();
    cmd_v = '0; mresp_v = 1; yumi = '1;
    #2;
    n_chk++; if (resp_v !== '0) begin n_fail++; $display("FAIL empty_resp_v: got %b expected 000", resp_v); end
    n_chk++; if (myumi !== 1'b0) begin n_fail++; $display("FAIL empty_yumi: got %b expected 0", myumi); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    cmd_v = 3'b010; mrdy = 1; mresp_v = 0; yumi = '0;
    repeat (3) tick();
    rst = 1; cmd_v = '1; mresp_v = 1; yumi = '1;
    #2;
    n_chk++; if ({cmd_rdy, resp_v, mcmd_v, myumi} !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %b expected all 0", {cmd_rdy, resp_v, mcmd_v, myumi}); end
    tick();
    rst = 0;
    #2;
    n_chk++; if (cmd_rdy !== 3'b001) begin n_fail++; $display("FAIL midreset_first_grant: got %b expected 001", cmd_rdy); end
    n_chk++; if (resp_v !== 3'b000) begin n_fail++; $display("FAIL midreset_fifo_empty: got %b expected 000", resp_v); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      cmd_v = NP'($urandom); mrdy = ($urandom_range(3) != 0);
      mresp_v = $urandom_range(1); yumi = NP'($urandom);
      set_data();
      #2; predict();
      n_chk++; if (mcmd_v !== exp_cv) begin n_fail++; $display("FAIL rnd_cmd_v[%0d]: got %b expected %b", i, mcmd_v, exp_cv); end
      n_chk++; if (cmd_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_cmd_ready[%0d]: got %b expected %b", i, cmd_rdy, exp_rdy); end
      n_chk++; if (resp_v !== exp_rv) begin n_fail++; $display("FAIL rnd_resp_v[%0d]: got %b expected %b", i, resp_v, exp_rv); end
      n_chk++; if (myumi !== exp_y) begin n_fail++; $display("FAIL rnd_yumi[%0d]: got %b expected %b", i, myumi, exp_y); end
      if (exp_cv) begin
        n_chk++; if (mcmd !== exp_cmd) begin n_fail++; $display("FAIL rnd_cmd_data[%0d]: got %h expected %h", i, mcmd, exp_cmd); end
      end
      n_chk++; if (resp !== mresp) begin n_fail++; $display("FAIL rnd_resp_data[%0d]: got %h expected %h", i, resp, mresp); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding_limit();
    test_order();
    test_full_pop();
    test_empty_resp();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
